axi_full_slave_ram: RTL and testbench

- Synthesizable AXI4-Full slave (responder) backed by an on-chip word RAM.
- It is the other end of the AXI-Full master port of the Paillier accelerator top: the accelerator reads operands from it and writes results back to it.
- Intended as the FPGA stand-in for external memory. It is the synthesizable counterpart of the behavioural AXI memory model used in simulation.
- Write and read channels operate independently and can be active concurrently.

---
 rtl/axi_full_slave_ram.sv | 233 +++++++++++++++++++++++
 tb/tb_axi_full_slave_ram.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_full_slave_ram.sv
// axi_full_slave_ram: AXI4-Full slave backed by an on-chip word RAM.
// INCR bursts at full data width only. Write and read paths are independent FSMs
// and may run concurrently. A same-cycle read and write of one word returns old data.
// Optional feature macro: AXI_RAM_ERR_RESP_EN (out-of-range beats answer SLVERR).
module axi_full_slave_ram #(
  parameter int unsigned C_S_AXI_ID_WIDTH   = 1,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 64,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 128,
  parameter int unsigned MEM_DEPTH_LOG2     = 10
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]                      S_AXI_AWLEN,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WLAST,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]                      S_AXI_ARLEN,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RLAST,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  localparam int unsigned ADDR_LSB  = $clog2(C_S_AXI_DATA_WIDTH / 8);
  localparam int unsigned STRB_W    = C_S_AXI_DATA_WIDTH / 8;
  localparam int unsigned MEM_DEPTH = 1 << MEM_DEPTH_LOG2;
`ifdef AXI_RAM_ERR_RESP_EN
  // Track the whole word address so beats that walk past the RAM can be flagged.
  localparam int unsigned WA_W = C_S_AXI_ADDR_WIDTH - ADDR_LSB;
`else
  localparam int unsigned WA_W = MEM_DEPTH_LOG2;
`endif
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {WIdle, WData, WResp} wr_state_e;
  typedef enum logic {RIdle, RData} rd_state_e;

  logic [C_S_AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Write path state
  wr_state_e                     wr_state_q;
  logic                          awready_q, wready_q, bvalid_q, wr_err_q;
  logic [1:0]                    bresp_q;
  logic [C_S_AXI_ID_WIDTH-1:0]   wr_id_q;
  logic [WA_W-1:0]               wr_wa_q;
  logic [7:0]                    wr_len_q, wr_cnt_q;
  logic                          wr_fire, wr_oor;
  logic [MEM_DEPTH_LOG2-1:0]     wr_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] wr_mask;

  // Read path state
  rd_state_e                     rd_state_q;
  logic                          arready_q, rvalid_q, rlast_q;
  logic [1:0]                    rresp_q;
  logic [C_S_AXI_ID_WIDTH-1:0]   rd_id_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
  logic [WA_W-1:0]               rd_wa_q;
  logic [7:0]                    rd_len_q, rd_cnt_q;
  logic                          rd_fetch, rd_oor, rd_done;
  logic [MEM_DEPTH_LOG2-1:0]     rd_idx;

  assign wr_fire = (wr_state_q == WData) && S_AXI_WVALID && wready_q;
  assign wr_idx  = wr_wa_q[MEM_DEPTH_LOG2-1:0];
  assign rd_idx  = rd_wa_q[MEM_DEPTH_LOG2-1:0];

  // Finish the burst on the beat whose RLAST handshakes; otherwise fetch whenever the
  // output register is empty or being consumed.
  assign rd_done  = rvalid_q && S_AXI_RREADY && rlast_q;
  assign rd_fetch = (rd_state_q == RData) && (!rvalid_q || (S_AXI_RREADY && !rlast_q));

`ifdef AXI_RAM_ERR_RESP_EN
  assign wr_oor = |wr_wa_q[WA_W-1:MEM_DEPTH_LOG2];
  assign rd_oor = |rd_wa_q[WA_W-1:MEM_DEPTH_LOG2];
`else
  assign wr_oor = 1'b0;
  assign rd_oor = 1'b0;
`endif

  // Expand byte strobes into a bit mask for the RAM write.
  always_comb begin
    wr_mask = '0;
    for (int b = 0; b < STRB_W; b++) begin
      wr_mask[b*8 +: 8] = {8{S_AXI_WSTRB[b]}};
    end
  end

  // RAM write port; the array is never reset.
  always_ff @(posedge S_AXI_ACLK) begin
    if (wr_fire && !wr_oor) begin
      mem[wr_idx] <= (mem[wr_idx] & ~wr_mask) | (S_AXI_WDATA & wr_mask);
    end
  end

  // Write FSM: accept AW, take LEN+1 beats (WLAST ignored), then hold B until BREADY.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wr_state_q <= WIdle;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_err_q   <= 1'b0;
      wr_id_q    <= '0;
      wr_wa_q    <= '0;
      wr_len_q   <= '0;
      wr_cnt_q   <= '0;
    end else begin
      unique case (wr_state_q)
        WIdle: begin
          awready_q <= 1'b1;
          if (S_AXI_AWVALID && awready_q) begin
            wr_id_q    <= S_AXI_AWID;
            wr_wa_q    <= S_AXI_AWADDR[ADDR_LSB +: WA_W];
            wr_len_q   <= S_AXI_AWLEN;
            wr_cnt_q   <= '0;
            wr_err_q   <= 1'b0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b1;
            wr_state_q <= WData;
          end
        end
        WData: begin
          if (wr_fire) begin
            wr_wa_q  <= wr_wa_q + WA_W'(1);
            wr_cnt_q <= wr_cnt_q + 8'd1;
            wr_err_q <= wr_err_q | wr_oor;
            if (wr_cnt_q == wr_len_q) begin
              wready_q   <= 1'b0;
              bvalid_q   <= 1'b1;
              bresp_q    <= (wr_err_q || wr_oor) ? RESP_SLVERR : RESP_OKAY;
              wr_state_q <= WResp;
            end
          end
        end
        WResp: begin
          if (S_AXI_BREADY) begin
            bvalid_q   <= 1'b0;
            awready_q  <= 1'b1;
            wr_state_q <= WIdle;
          end
        end
        default: wr_state_q <= WIdle;
      endcase
    end
  end

  // Read FSM: accept AR, stream LEN+1 registered RAM words, hold each beat while stalled.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rd_state_q <= RIdle;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      rd_id_q    <= '0;
      rd_wa_q    <= '0;
      rd_len_q   <= '0;
      rd_cnt_q   <= '0;
    end else begin
      unique case (rd_state_q)
        RIdle: begin
          arready_q <= 1'b1;
          if (S_AXI_ARVALID && arready_q) begin
            rd_id_q    <= S_AXI_ARID;
            rd_wa_q    <= S_AXI_ARADDR[ADDR_LSB +: WA_W];
            rd_len_q   <= S_AXI_ARLEN;
            rd_cnt_q   <= '0;
            arready_q  <= 1'b0;
            rd_state_q <= RData;
          end
        end
        RData: begin
          if (rd_done) begin
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            arready_q  <= 1'b1;
            rd_state_q <= RIdle;
          end else if (rd_fetch) begin
            rdata_q  <= rd_oor ? '0 : mem[rd_idx];
            rresp_q  <= rd_oor ? RESP_SLVERR : RESP_OKAY;
            rlast_q  <= (rd_cnt_q == rd_len_q);
            rvalid_q <= 1'b1;
            rd_wa_q  <= rd_wa_q + WA_W'(1);
            rd_cnt_q <= rd_cnt_q + 8'd1;
          end
        end
      endcase
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BID     = wr_id_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RID     = rd_id_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RLAST   = rlast_q;
  assign S_AXI_RVALID  = rvalid_q;

  // Address bits below a word, and above the RAM when not range-checking, are don't-care.
  logic unused_inputs;
`ifdef AXI_RAM_ERR_RESP_EN
  assign unused_inputs = ^{S_AXI_WLAST, S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};
`else
  assign unused_inputs = ^{S_AXI_WLAST,
                           S_AXI_AWADDR[ADDR_LSB-1:0],
                           S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB+MEM_DEPTH_LOG2],
                           S_AXI_ARADDR[ADDR_LSB-1:0],
                           S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB+MEM_DEPTH_LOG2]};
`endif

endmodule

// File: tb/tb_axi_full_slave_ram.sv
// Scoreboard bench for axi_full_slave_ram: stimulus pushes expected B/R responses,
// a falling-edge monitor pops and compares them on each handshake.
`timescale 1ns/1ps
module tb_axi_full_slave_ram;
  localparam int unsigned ID_W = 1, ADDR_W = 64, DATA_W = 128, DEPTH = 1024, STRB_W = 16;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;
  typedef logic [DATA_W-1:0] data_t;
  typedef struct { logic [ID_W-1:0] id; data_t data; logic last; logic [1:0] resp; } r_exp_t;
  typedef struct { logic [ID_W-1:0] id; logic [1:0] resp; } b_exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [ID_W-1:0]   S_AXI_AWID, S_AXI_BID, S_AXI_ARID, S_AXI_RID;
  logic [ADDR_W-1:0] S_AXI_AWADDR, S_AXI_ARADDR;
  logic [7:0]        S_AXI_AWLEN, S_AXI_ARLEN;
  logic              S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WLAST, S_AXI_WVALID, S_AXI_WREADY;
  logic [DATA_W-1:0] S_AXI_WDATA, S_AXI_RDATA;
  logic [STRB_W-1:0] S_AXI_WSTRB;
  logic [1:0]        S_AXI_BRESP, S_AXI_RRESP;
  logic              S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
  logic              S_AXI_RLAST, S_AXI_RVALID, S_AXI_RREADY;

  axi_full_slave_ram dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RID(S_AXI_RID), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
  );

  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_pass = 0;
  int     r_beats = 0;
  int     early_last = -1;
  bit     rready_toggle = 1'b0;
  r_exp_t rq[$];
  b_exp_t bq[$];
  data_t  model [DEPTH];
  data_t  wbuf [256];
  logic [STRB_W-1:0] sbuf [256];

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic data_t merge(input data_t old, input data_t nw, input logic [STRB_W-1:0] s);
    data_t r = old;
    for (int b = 0; b < STRB_W; b++) if (s[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  // Monitor: compare every R/B handshake against the scoreboard, and check R holds when stalled.
  initial begin : monitor
    r_exp_t e;
    b_exp_t be;
    bit stalled;
    data_t hd;
    logic hl;
    logic [ID_W-1:0] hid;
    stalled = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("r_hold_valid", S_AXI_RVALID, 1'b1);
          check("r_hold_data", S_AXI_RDATA, hd);
          check("r_hold_last", S_AXI_RLAST, hl);
          check("r_hold_id", S_AXI_RID, hid);
        end
        stalled = 1'b0;
        if (S_AXI_RVALID && S_AXI_RREADY) begin
          r_beats++;
          if (rq.size() == 0) begin
            n_checks++;
            $display("FAIL r_unexpected: got beat %h, expected no beat", S_AXI_RDATA);
          end else begin
            e = rq.pop_front();
            check("r_data", S_AXI_RDATA, e.data);
            check("r_last", S_AXI_RLAST, e.last);
            check("r_id", S_AXI_RID, e.id);
            check("r_resp", S_AXI_RRESP, e.resp);
          end
        end else if (S_AXI_RVALID) begin
          stalled = 1'b1;
          hd = S_AXI_RDATA;
          hl = S_AXI_RLAST;
          hid = S_AXI_RID;
        end
        if (S_AXI_BVALID && S_AXI_BREADY) begin
          if (bq.size() == 0) begin
            n_checks++;
            $display("FAIL b_unexpected: got B id %0d, expected no response", S_AXI_BID);
          end else begin
            be = bq.pop_front();
            check("b_id", S_AXI_BID, be.id);
            check("b_resp", S_AXI_BRESP, be.resp);
          end
        end
      end
    end
  end

  // RREADY: held high, or toggled every cycle when requested.
  initial begin
    S_AXI_RREADY = 1'b0;
    forever begin
      @(posedge clk);
      #1 S_AXI_RREADY = rready_toggle ? ~S_AXI_RREADY : 1'b1;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no end of test, expected finish within 300 us");
    $fatal(1);
  end

  task automatic aw_issue(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                          input logic [7:0] len);
    bit done = 1'b0;
    S_AXI_AWID = id; S_AXI_AWADDR = addr; S_AXI_AWLEN = len; S_AXI_AWVALID = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (S_AXI_AWREADY) begin @(posedge clk); #1; done = 1'b1; end
    end
    S_AXI_AWVALID = 1'b0;
    if (!done) begin n_checks++; $display("FAIL aw_timeout: got no AWREADY, expected handshake"); end
  endtask

  task automatic ar_issue(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                          input logic [7:0] len);
    bit done = 1'b0;
    S_AXI_ARID = id; S_AXI_ARADDR = addr; S_AXI_ARLEN = len; S_AXI_ARVALID = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (S_AXI_ARREADY) begin @(posedge clk); #1; done = 1'b1; end
    end
    S_AXI_ARVALID = 1'b0;
    if (!done) begin n_checks++; $display("FAIL ar_timeout: got no ARREADY, expected handshake"); end
  endtask

  task automatic w_beat(input data_t d, input logic [STRB_W-1:0] s, input logic last);
    bit done = 1'b0;
    S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WLAST = last; S_AXI_WVALID = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (S_AXI_WREADY) begin @(posedge clk); #1; done = 1'b1; end
    end
    S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
    if (!done) begin n_checks++; $display("FAIL w_timeout: got no WREADY, expected handshake"); end
  endtask

  // Write wbuf/sbuf[0..len]; update the memory model only for beats that should land.
  task automatic write_burst(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                             input logic [7:0] len, input logic [1:0] resp, input bit apply);
    logic [9:0] wi;
    bq.push_back('{id, resp});
    aw_issue(id, addr, len);
    for (int i = 0; i <= int'(len); i++) begin
      wi = addr[4 +: 10] + 10'(i);
      if (apply) model[wi] = merge(model[wi], wbuf[i], sbuf[i]);
      w_beat(wbuf[i], sbuf[i], (i == int'(len)) || (i == early_last));
    end
  endtask

  task automatic read_burst(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                            input logic [7:0] len);
    logic [9:0] ri;
    for (int i = 0; i <= int'(len); i++) begin
      ri = addr[4 +: 10] + 10'(i);
      rq.push_back('{id, model[ri], (i == int'(len)), OKAY});
    end
    ar_issue(id, addr, len);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int i = 0;
    while ((rq.size() != 0 || bq.size() != 0) && i < budget) begin
      @(posedge clk); #1; i++;
    end
    if (rq.size() != 0 || bq.size() != 0) begin
      n_checks++;
      $display("FAIL %s_timeout: got %0d R and %0d B pending, expected 0", name, rq.size(),
               bq.size());
      rq.delete(); bq.delete();
    end else begin
      @(negedge clk);
      check({name, "_rvalid_idle"}, S_AXI_RVALID, 1'b0);
      check({name, "_bvalid_idle"}, S_AXI_BVALID, 1'b0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int base;
    bit seen;
    rst_n = 1'b0;
    S_AXI_AWID = '0; S_AXI_AWADDR = '0; S_AXI_AWLEN = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WLAST = 1'b0; S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b1;
    S_AXI_ARID = '0; S_AXI_ARADDR = '0; S_AXI_ARLEN = '0; S_AXI_ARVALID = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", S_AXI_AWREADY, 1'b0);
    check("rst_arready", S_AXI_ARREADY, 1'b0);
    check("rst_wready", S_AXI_WREADY, 1'b0);
    check("rst_bvalid", S_AXI_BVALID, 1'b0);
    check("rst_rvalid", S_AXI_RVALID, 1'b0);
    check("rst_rlast", S_AXI_RLAST, 1'b0);
    check("rst_rdata", S_AXI_RDATA, '0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("awready_first_edge", S_AXI_AWREADY, 1'b1);
    check("arready_first_edge", S_AXI_ARREADY, 1'b1);

    // 4-beat write/read at 0; WLAST also pulsed early on beat 2 and must be ignored.
    wbuf[0] = {16{8'h11}}; wbuf[1] = {16{8'h22}}; wbuf[2] = {16{8'h33}}; wbuf[3] = {16{8'h44}};
    for (int i = 0; i < 256; i++) sbuf[i] = '1;
    early_last = 1;
    write_burst(1'b1, 64'h0, 8'd3, OKAY, 1'b1);
    early_last = -1;
    wait_drain("wr4", 100);
    read_burst(1'b1, 64'h0, 8'd3);
    wait_drain("rd4", 100);

    // Partial strobe on word 5: clear, then write all-ones with low 4 bytes enabled.
    wbuf[0] = '0;
    write_burst(1'b0, 64'h50, 8'd0, OKAY, 1'b1);
    wait_drain("wr5_clear", 100);
    wbuf[0] = '1; sbuf[0] = 16'h000F;
    write_burst(1'b0, 64'h50, 8'd0, OKAY, 1'b1);
    sbuf[0] = '1;
    wait_drain("wr5_strb", 100);
    rq.push_back('{1'b0, 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 1'b1, OKAY});
    ar_issue(1'b0, 64'h50, 8'd0);
    wait_drain("rd5", 100);

    // 32-beat read with RREADY toggling.
    for (int i = 0; i < 32; i++) wbuf[i] = {4{32'hC0DE_0000 + 32'(i)}};
    write_burst(1'b0, 64'd1600, 8'd31, OKAY, 1'b1);
    wait_drain("wr32", 200);
    rready_toggle = 1'b1;
    read_burst(1'b1, 64'd1600, 8'd31);
    wait_drain("rd32_stall", 300);
    rready_toggle = 1'b0;

`ifdef AXI_RAM_ERR_RESP_EN
    // Out-of-range write leaves RAM alone; out-of-range read returns zero with SLVERR.
    wbuf[0] = '1;
    write_burst(1'b1, 64'h4000, 8'd0, SLVERR, 1'b0);
    wait_drain("wr_oor", 100);
    rq.push_back('{1'b0, {16{8'h11}}, 1'b1, OKAY});
    ar_issue(1'b0, 64'h0, 8'd0);
    wait_drain("rd_word0", 100);
    rq.push_back('{1'b1, '0, 1'b1, SLVERR});
    ar_issue(1'b1, 64'h4000, 8'd0);
    wait_drain("rd_oor", 100);
`else
    // Burst starting at the last word wraps its second beat into word 0.
    wbuf[0] = {16{8'hA5}}; wbuf[1] = {16{8'h5A}};
    write_burst(1'b1, 64'h3FF0, 8'd1, OKAY, 1'b1);
    wait_drain("wr_wrap", 100);
    rq.push_back('{1'b0, {16{8'h5A}}, 1'b1, OKAY});
    ar_issue(1'b0, 64'h0, 8'd0);
    wait_drain("rd_word0", 100);
    read_burst(1'b1, 64'h3FF0, 8'd1);
    wait_drain("rd_wrap", 100);
`endif

    // Concurrent 32-beat write (words 200..231) and read (words 100..131), B stalled 5 cycles.
    for (int i = 0; i < 32; i++) wbuf[i] = {4{32'hBEEF_0000 + 32'(i)}};
    S_AXI_BREADY = 1'b0;
    fork
      write_burst(1'b1, 64'd3200, 8'd31, OKAY, 1'b1);
      read_burst(1'b0, 64'd1600, 8'd31);
    join
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = S_AXI_BVALID;
    end
    check("bvalid_seen", seen, 1'b1);
    repeat (5) begin
      @(negedge clk);
      check("bstall_bvalid", S_AXI_BVALID, 1'b1);
      check("bstall_awready", S_AXI_AWREADY, 1'b0);
    end
    @(posedge clk); #1 S_AXI_BREADY = 1'b1;
    wait_drain("concurrent", 300);

    // Reset in the middle of a 32-beat read, then a fresh 4-beat read.
    read_burst(1'b0, 64'd1600, 8'd31);
    base = r_beats;
    for (int i = 0; i < 100 && (r_beats - base) < 10; i++) begin
      @(posedge clk); #1;
    end
    check("mid_burst_reached", (r_beats - base) >= 10, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_rvalid", S_AXI_RVALID, 1'b0);
    check("arst_bvalid", S_AXI_BVALID, 1'b0);
    check("arst_awready", S_AXI_AWREADY, 1'b0);
    check("arst_arready", S_AXI_ARREADY, 1'b0);
    rq.delete(); bq.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    read_burst(1'b1, 64'd3200, 8'd3);
    wait_drain("rd_after_rst", 100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
